// File: rtl/hazard_if.sv
// Hazard controller signal bundle: ID/EX/MEM hazard inputs and pipeline enable outputs.
// The pipeline side drives through master; hazard_ctrl connects as slave.
interface hazard_if;
  logic [3:0]  ID_RegRs;
  logic [3:0]  ID_RegRt;
  logic        ID_UseRs;
  logic        ID_UseRt;
  logic        ID_MemWrite;
  logic        ID_BranchReg;
  logic        branch_taken;
  logic        EX_MemRead;
  logic        EX_RegWrite;
  logic [3:0]  EX_RegRd;
  logic        MEM_MemRead;
  logic [3:0]  MEM_RegRd;
  logic        IF_halt;
  logic        mem_busy;
  logic        PC_write;
  logic        IF_ID_write;
  logic        IF_ID_flush;
  logic        ID_EX_bubble;
  logic        pipe_write;
  logic        halted;
  logic [15:0] stall_cycles;

  modport master (
    output ID_RegRs, ID_RegRt, ID_UseRs, ID_UseRt, ID_MemWrite, ID_BranchReg, branch_taken,
           EX_MemRead, EX_RegWrite, EX_RegRd, MEM_MemRead, MEM_RegRd, IF_halt, mem_busy,
    input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_write, halted, stall_cycles
  );

  modport slave (
    input  ID_RegRs, ID_RegRt, ID_UseRs, ID_UseRt, ID_MemWrite, ID_BranchReg, branch_taken,
           EX_MemRead, EX_RegWrite, EX_RegRd, MEM_MemRead, MEM_RegRd, IF_halt, mem_busy,
    output PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_write, halted, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use and BR-register stalls, branch flush,
// memory freeze, HLT drain and a saturating stall-cycle counter.
module hazard_ctrl (
  input logic    clk,
  input logic    rst,
  hazard_if.slave hz
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        load_use, br_dep, stall;

  // Register 0 is hardwired, so a zero destination never creates a dependency.
  always_comb begin
    load_use = hz.EX_MemRead && (hz.EX_RegRd != 4'd0) &&
               ((hz.ID_UseRs && (hz.EX_RegRd == hz.ID_RegRs)) ||
                (hz.ID_UseRt && !hz.ID_MemWrite && (hz.EX_RegRd == hz.ID_RegRt)));
    br_dep   = hz.ID_BranchReg &&
               ((hz.EX_RegWrite && (hz.EX_RegRd != 4'd0) && (hz.EX_RegRd == hz.ID_RegRs)) ||
                (hz.MEM_MemRead && (hz.MEM_RegRd != 4'd0) && (hz.MEM_RegRd == hz.ID_RegRs)));
    stall    = load_use || br_dep;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      cnt_q       <= 3'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        // A flushed or stalled HLT is not yet committed to the drain.
        if (hz.IF_halt && !hz.mem_busy && !stall && !hz.branch_taken) begin
          state_d = StDrain;
          cnt_d   = 3'd4;
        end
      end
      StDrain: begin
        if (!hz.mem_busy) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = StHalted;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != StHalted) && (stall || hz.mem_busy) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_comb begin
    hz.PC_write     = 1'b1;
    hz.IF_ID_write  = 1'b1;
    hz.IF_ID_flush  = 1'b0;
    hz.ID_EX_bubble = 1'b0;
    hz.pipe_write   = 1'b1;
    if (hz.mem_busy || (state_q == StHalted)) begin
      hz.PC_write    = 1'b0;
      hz.IF_ID_write = 1'b0;
      hz.pipe_write  = 1'b0;
    end else if (stall) begin
      // Branch outcome is ignored here: its operand is not yet available.
      hz.PC_write     = 1'b0;
      hz.IF_ID_write  = 1'b0;
      hz.ID_EX_bubble = 1'b1;
    end else if (state_q == StDrain) begin
      hz.PC_write    = 1'b0;
      hz.IF_ID_flush = 1'b1;
    end else if (hz.branch_taken) begin
      hz.IF_ID_flush = 1'b1;
    end
  end

  assign hz.halted       = (state_q == StHalted);
  assign hz.stall_cycles = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage 16-bit core. It detects load-use and branch-register data hazards that the forwarding paths cannot cover, and stalls or bubbles the pipeline accordingly. It also flushes IF/ID on taken branches, freezes the whole pipeline while memory is busy, drains the pipeline after a HLT fetch, and counts stall cycles. It sits beside the forwarding unit and drives the enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ID_RegRs, ID_RegRt  in  4  source register IDs of the instruction in ID.
- ID_UseRs, ID_UseRt  in  1  instruction in ID actually reads Rs / Rt.
- ID_MemWrite  in  1  instruction in ID is a store; its Rt is store data.
- ID_BranchReg  in  1  instruction in ID is BR (target read from Rs in ID).
- branch_taken  in  1  branch in ID resolved taken this cycle.
- EX_MemRead, EX_RegWrite  in  1  control bits of the instruction in EX.
- EX_RegRd  in  4  destination register of the instruction in EX.
- MEM_MemRead  in  1  the instruction in MEM is a load.
- MEM_RegRd  in  4  destination register of the instruction in MEM.
- IF_halt  in  1  the instruction in IF is HLT.
- mem_busy  in  1  I- or D-memory miss in progress.
- PC_write  out  1  PC register enable.
- IF_ID_write  out  1  IF/ID enable.
- IF_ID_flush  out  1  load a NOP into IF/ID.
- ID_EX_bubble  out  1  load zeroed control into ID/EX.
- pipe_write  out  1  enable for ID/EX, EX/MEM and MEM/WB.
- halted  out  1  registered; the pipeline has fully drained after HLT.
- stall_cycles  out  16  registered saturating stall counter.

## Operation
- Register 0 never causes a hazard. Every compare requires the destination register to be nonzero.
- load_use: EX_MemRead and EX_RegRd == ID_RegRs with ID_UseRs, or EX_RegRd == ID_RegRt with ID_UseRt and not ID_MemWrite.
  - Store data is excluded because MEM-MEM forwarding covers it.
- br_dep: ID_BranchReg and either of the following:
  - EX_RegWrite and EX_RegRd == ID_RegRs;
  - MEM_MemRead and MEM_RegRd == ID_RegRs.
- stall = load_use or br_dep.
- FSM states:
  - RUN: normal operation.
  - DRAIN: halt accepted; a 3-bit counter cnt is loaded with 4.
  - HALTED: terminal state.
- FSM transitions:
  - RUN -> DRAIN when IF_halt, not mem_busy, not stall and not branch_taken. A flush kills a HLT sitting in IF.
  - DRAIN: cnt decrements on each cycle without mem_busy; moves to HALTED on the edge where cnt goes 1 -> 0.
  - HALTED exits only on rst.
- Output priority, highest first (combinational):
  1. mem_busy, any state: all enables 0, IF_ID_flush 0, ID_EX_bubble 0.
  2. HALTED: all enables 0, IF_ID_flush 0, ID_EX_bubble 0.
  3. stall, in RUN or DRAIN: PC_write 0, IF_ID_write 0, ID_EX_bubble 1, pipe_write 1. branch_taken is ignored because the branch is unresolved.
  4. DRAIN: PC_write 0, IF_ID_write 1, IF_ID_flush 1, pipe_write 1, so NOPs follow the HLT.
  5. branch_taken in RUN: PC_write 1, IF_ID_write 1, IF_ID_flush 1, pipe_write 1.
  6. Otherwise: PC_write 1, IF_ID_write 1, pipe_write 1, others 0.
- stall_cycles increments by 1 on each edge where the state is not HALTED and (stall or mem_busy) holds. It holds at 0xFFFF.
- halted is 1 exactly when the state is HALTED.

## Timing
- Hazard and flush outputs are combinational, in the same cycle as the inputs.
- halted and stall_cycles are registered.
- Reset values: state RUN, cnt 0, halted 0, stall_cycles 0.
- With idle inputs after reset: PC_write 1, IF_ID_write 1, pipe_write 1, IF_ID_flush 0, ID_EX_bubble 0.
- Halt latency: HLT accepted at edge t, then IF_ID_flush is asserted in cycles t+1..t+4 and halted = 1 from edge t+4. With no mem_busy, this is 4 cycles after acceptance.
- Each mem_busy cycle during DRAIN adds one cycle to the halt latency.
- A load-use stall lasts 1 cycle unless the inputs keep matching.
- A BR depending on a load in EX stalls 2 cycles: load_use or br_dep in EX, then br_dep in MEM.
- rst asserted mid-DRAIN returns the block to RUN immediately; halted drops asynchronously.

## Test plan
- Load-use: EX_MemRead=1, EX_RegRd=3, ID_RegRs=3, ID_UseRs=1 -> PC_write=0, IF_ID_write=0, ID_EX_bubble=1; stall_cycles goes 0 -> 1.
- Store data and R0: the same load with ID_RegRt=3, ID_UseRt=1, ID_MemWrite=1 -> no stall. EX_RegRd=0 matching a source -> no stall.
- BR after load: ID_BranchReg=1, Rs=5; cycle 1 has EX load to R5, cycle 2 has MEM load to R5 -> stall in both cycles, then branch_taken=1 -> IF_ID_flush=1, PC_write=1.
- Freeze priority: mem_busy=1 together with load_use and branch_taken for 3 cycles -> all enables 0 and flush/bubble 0 in each; stall_cycles = 3.
- Halt: IF_halt=1 at edge t -> IF_ID_flush=1 and PC_write=0 for cycles t+1..t+4, halted=1 from t+4. Repeat with mem_busy=1 for 2 cycles during DRAIN -> halted at t+6. Repeat with IF_halt and branch_taken together -> no halt.
- Reset and saturation: rst during DRAIN -> halted 0 and state RUN, stall_cycles 0. Force 65540 stall cycles -> stall_cycles = 0xFFFF.
